// File: rtl/audio_sample_feeder.sv
// Sample-rate pacing FIFO feeding the audio DAC stage.
// Ports: clk/rst (sync, active-high); in_data/in_valid/in_ready push side;
//   enable, volume, underrun_clr controls; pcm_out/sample_tick DAC side;
//   level FIFO occupancy; underrun sticky empty-at-strobe flag.
module audio_sample_feeder #(
  parameter int CLK_DIV = 3125,
  parameter int DEPTH   = 64,
  parameter int ADDR_W  = 6
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [15:0]       in_data,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              enable,
  input  logic [2:0]        volume,
  input  logic              underrun_clr,
  output logic [15:0]       pcm_out,
  output logic              sample_tick,
  output logic [ADDR_W:0]   level,
  output logic              underrun
);

  localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [DIV_W-1:0]  DIV_MAX = DIV_W'(CLK_DIV - 1);
  localparam logic [ADDR_W:0]   FULL    = (ADDR_W + 1)'(DEPTH);

  logic [15:0]        r_mem [DEPTH];
  logic [ADDR_W-1:0]  r_wptr;
  logic [ADDR_W-1:0]  r_rptr;
  logic [ADDR_W:0]    r_level;
  logic [DIV_W-1:0]   r_div;
  logic [15:0]        r_pcm;
  logic               r_tick;
  logic               r_under;

  logic               w_wr;
  logic               w_strobe;
  logic               w_pop;
  logic               w_empty_hit;
  logic signed [15:0] w_shift;

  assign in_ready    = (r_level != FULL);
  assign w_wr        = in_valid && in_ready;
  assign w_strobe    = enable && (r_div == DIV_MAX);
  assign w_pop       = w_strobe && (r_level != '0);
  assign w_empty_hit = w_strobe && (r_level == '0);
  assign w_shift     = $signed(r_mem[r_rptr]) >>> volume;

  // Storage carries no reset; pointers define what is valid.
  always_ff @(posedge clk) begin
    if (w_wr) r_mem[r_wptr] <= in_data;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_level <= '0;
      r_div   <= '0;
      r_pcm   <= 16'h8000;
      r_tick  <= 1'b0;
      r_under <= 1'b0;
    end else begin
      if (w_wr)  r_wptr <= r_wptr + ADDR_W'(1);
      if (w_pop) r_rptr <= r_rptr + ADDR_W'(1);

      case ({w_wr, w_pop})
        2'b10:   r_level <= r_level + (ADDR_W + 1)'(1);
        2'b01:   r_level <= r_level - (ADDR_W + 1)'(1);
        default: r_level <= r_level;
      endcase

      if (!enable || w_strobe) r_div <= '0;
      else                     r_div <= r_div + DIV_W'(1);

      r_tick <= w_strobe;

      // Flipping the sign bit maps two's complement to offset binary.
      if (!enable)    r_pcm <= 16'h8000;
      else if (w_pop) r_pcm <= {~w_shift[15], w_shift[14:0]};

      // A new underrun outranks a simultaneous clear.
      if (w_empty_hit)       r_under <= 1'b1;
      else if (underrun_clr) r_under <= 1'b0;
    end
  end

  assign pcm_out     = r_pcm;
  assign sample_tick = r_tick;
  assign level       = r_level;
  assign underrun    = r_under;

endmodule

// File: tb/tb_audio_sample_feeder.sv
// Self-checking bench for audio_sample_feeder (CLK_DIV=4, DEPTH=4).
// Queue-based reference model compared every cycle plus directed literals.
module tb_audio_sample_feeder;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] in_data;
  logic        in_valid;
  logic        in_ready;
  logic        enable;
  logic [2:0]  volume;
  logic        underrun_clr;
  logic [15:0] pcm_out;
  logic        sample_tick;
  logic [2:0]  level;
  logic        underrun;

  int checks   = 0;
  int failures = 0;
  bit chk_en   = 0;

  audio_sample_feeder #(
    .CLK_DIV(4),
    .DEPTH(4),
    .ADDR_W(2)
  ) dut (
    .clk(clk),
    .rst(rst),
    .in_data(in_data),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .enable(enable),
    .volume(volume),
    .underrun_clr(underrun_clr),
    .pcm_out(pcm_out),
    .sample_tick(sample_tick),
    .level(level),
    .underrun(underrun)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", nm, act, exp);
    end
  endtask

  // Reference model: a queue of pending samples and a count of
  // enabled cycles; an output is due every fourth enabled cycle.
  logic [15:0] m_q[$];
  int          m_phase;
  logic [15:0] m_pcm;
  logic        m_tick;
  logic        m_under;

  always @(posedge clk) begin : model
    bit   accept;
    bit   due;
    bit   starved;
    int   s;
    logic [15:0] x;
    if (rst) begin
      m_q.delete();
      m_phase = 0;
      m_pcm   = 16'h8000;
      m_tick  = 1'b0;
      m_under = 1'b0;
    end else begin
      accept  = in_valid && (m_q.size() < 4);
      due     = enable && ((m_phase + 1) % 4 == 0);
      starved = due && (m_q.size() == 0);
      m_tick  = due;
      m_phase = enable ? m_phase + 1 : 0;
      if (!enable) begin
        m_pcm = 16'h8000;
      end else if (due && !starved) begin
        x = m_q.pop_front();
        s = int'($signed(x)) >>> volume;
        m_pcm = 16'(s + 32768);
      end
      if (starved)           m_under = 1'b1;
      else if (underrun_clr) m_under = 1'b0;
      if (accept) m_q.push_back(in_data);
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      chk("mon_pcm", pcm_out, m_pcm);
      chk("mon_tick", sample_tick, m_tick);
      chk("mon_level", level, m_q.size());
      chk("mon_ready", in_ready, m_q.size() < 4);
      chk("mon_underrun", underrun, m_under);
    end
  end

  task automatic push(input logic [15:0] d);
    in_valid = 1'b1;
    in_data  = d;
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic wait_tick(input string nm, output int n,
                           output logic [15:0] v);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!sample_tick && n < 20);
    chk({nm, "_tick_seen"}, sample_tick, 1'b1);
    v = pcm_out;
  endtask

  logic [15:0] exp2 [4] = '{16'hFFFF, 16'h0000, 16'h7FFE, 16'h8100};
  logic [15:0] in2  [4] = '{16'h7FFF, 16'h8000, 16'hFFFE, 16'h0100};

  initial begin
    int          n;
    int          ticks;
    logic [15:0] v;
    rst = 1'b1; in_data = '0; in_valid = 1'b0; enable = 1'b0;
    volume = '0; underrun_clr = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    chk_en = 1;

    // 1: idle after reset
    chk("t1_pcm", pcm_out, 16'h8000);
    chk("t1_level", level, 0);
    chk("t1_ready", in_ready, 1);
    chk("t1_underrun", underrun, 0);
    ticks = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (sample_tick) ticks++;
    end
    chk("t1_no_ticks", ticks, 0);

    // 2: conversion and volume
    for (int i = 0; i < 4; i++) push(in2[i]);
    enable = 1'b1;
    for (int i = 0; i < 4; i++) begin
      wait_tick("t2", n, v);
      chk("t2_spacing", n, 4);
      chk("t2_value", v, exp2[i]);
    end
    enable = 1'b0;
    @(negedge clk);
    volume = 3'd1;
    push(16'hFFFE);
    push(16'h0100);
    enable = 1'b1;
    wait_tick("t2v", n, v);
    chk("t2_vol_a", v, 16'h7FFF);
    wait_tick("t2v", n, v);
    chk("t2_vol_b", v, 16'h8080);
    enable = 1'b0;
    volume = 3'd0;
    @(negedge clk);

    // 3: full FIFO
    for (int i = 0; i < 5; i++) begin
      in_valid = 1'b1;
      in_data  = 16'(16'h1111 * (i + 1));
      @(negedge clk);
      if (i == 3) begin
        chk("t3_ready_full", in_ready, 0);
        chk("t3_level_full", level, 4);
      end
    end
    in_valid = 1'b0;
    chk("t3_model_level", m_q.size(), 4);
    enable = 1'b1;
    for (int i = 0; i < 4; i++) begin
      wait_tick("t3", n, v);
      chk("t3_value", v, 16'(16'h1111 * (i + 1) + 16'h8000));
    end
    chk("t3_fifth_dropped", level, 0);
    enable = 1'b0;
    @(negedge clk);

    // 4: underrun
    push(16'h1234);
    enable = 1'b1;
    wait_tick("t4a", n, v);
    chk("t4_first", v, 16'h9234);
    chk("t4_no_under_yet", underrun, 0);
    wait_tick("t4b", n, v);
    chk("t4_hold", v, 16'h9234);
    chk("t4_under_set", underrun, 1);
    repeat (3) @(negedge clk);
    underrun_clr = 1'b1;
    @(negedge clk);
    chk("t4_strobe_with_clr", sample_tick, 1);
    chk("t4_set_wins", underrun, 1);
    @(negedge clk);
    underrun_clr = 1'b0;
    chk("t4_cleared", underrun, 0);
    enable = 1'b0;
    @(negedge clk);

    // 5: streaming with wrap and coincident read/write
    begin
      int   idx;
      int   got;
      int   coinc;
      int   cyc;
      int   prev_lvl;
      bit   acc;
      idx = 1; got = 0; coinc = 0; cyc = 0;
      enable = 1'b1;
      while (got < 12 && cyc < 200) begin
        in_valid = (idx <= 12);
        in_data  = 16'(idx);
        acc      = in_valid && in_ready;
        prev_lvl = int'(level);
        @(negedge clk);
        cyc++;
        if (acc) idx++;
        if (sample_tick) begin
          chk("t5_no_underrun", prev_lvl != 0, 1);
          chk("t5_value", pcm_out, 16'(16'h8001 + got));
          got++;
          if (acc) begin
            coinc++;
            chk("t5_level_same", level, prev_lvl);
          end
        end
      end
      in_valid = 1'b0;
      chk("t5_count", got, 12);
      chk("t5_all_written", idx, 13);
      chk("t5_coincidence_seen", coinc != 0, 1);
    end
    enable = 1'b0;
    @(negedge clk);

    // 6: reset mid-operation
    for (int i = 1; i <= 4; i++) push(16'(16'h0100 * i));
    enable = 1'b1;
    wait_tick("t6a", n, v);
    chk("t6_pre_pcm", v, 16'h8100);
    chk("t6_pre_level", level, 3);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("t6_level", level, 0);
    chk("t6_pcm", pcm_out, 16'h8000);
    chk("t6_underrun", underrun, 0);
    wait_tick("t6b", n, v);
    chk("t6_restart", n, 4);
    enable = 1'b0;
    underrun_clr = 1'b1;
    @(negedge clk);
    underrun_clr = 1'b0;

    // Random traffic against the model
    enable = 1'b1;
    for (int i = 0; i < 3000; i++) begin
      in_valid     = 1'($urandom_range(0, 1));
      in_data      = 16'($urandom);
      volume       = 3'($urandom_range(0, 7));
      underrun_clr = ($urandom_range(0, 15) == 0);
      if ($urandom_range(0, 63) == 0) enable = ~enable;
      rst          = ($urandom_range(0, 255) == 0);
      @(negedge clk);
    end
    rst = 1'b0;
    in_valid = 1'b0;
    @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
